// File: rtl/muldiv_sched.sv
// Multi-cycle arithmetic scheduler: issues one DIV/DIVU/MULT/MULTU/CLZ op,
// tracks the unit's busy handshake and is the single writer of HI/LO.
module muldiv_sched #(
    parameter int TIMEOUT = 64,
    parameter int ARM_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        stall,
    output logic [4:0]  unit_start,
    input  logic [4:0]  unit_busy,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic [31:0] divu_hi,
    input  logic [31:0] divu_lo,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] multu_hi,
    input  logic [31:0] multu_lo,
    input  logic [31:0] clz_result,
    output logic        hi_wea,
    output logic        lo_wea,
    output logic [31:0] hi_in,
    output logic [31:0] lo_in,
    output logic        gpr_wea,
    output logic [31:0] gpr_data,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, COMMIT} state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] ARM_LAST = 10'(ARM_MAX - 1);

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] wdata_q;
    logic [9:0]  cnt;
    logic [9:0]  cnt_inc;
    logic        sel_busy;
    logic        accept;
    logic [31:0] hi_sel;
    logic [31:0] lo_sel;

    // {hi, lo, gpr} write enables committed for each op code
    function automatic logic [2:0] wr_mask(input logic [2:0] op);
        unique case (op)
            3'd0, 3'd1, 3'd2, 3'd3: wr_mask = 3'b110;
            3'd4:                   wr_mask = 3'b001;
            3'd5:                   wr_mask = 3'b100;
            3'd6:                   wr_mask = 3'b010;
            default:                wr_mask = 3'b000;
        endcase
    endfunction

    assign op_ready = (state == IDLE) && ~|unit_busy;
    assign stall    = (state != IDLE);
    assign accept   = op_valid && op_ready;
    assign cnt_inc  = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;

    always_comb begin
        sel_busy = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        unique case (op_q)
            3'd0: begin sel_busy = unit_busy[0]; hi_sel = div_hi;   lo_sel = div_lo;   end
            3'd1: begin sel_busy = unit_busy[1]; hi_sel = divu_hi;  lo_sel = divu_lo;  end
            3'd2: begin sel_busy = unit_busy[2]; hi_sel = mult_hi;  lo_sel = mult_lo;  end
            3'd3: begin sel_busy = unit_busy[3]; hi_sel = multu_hi; lo_sel = multu_lo; end
            3'd4: sel_busy = unit_busy[4];
            3'd5: hi_sel = wdata_q;
            3'd6: lo_sel = wdata_q;
            default: ;
        endcase
    end

    assign hi_in    = hi_wea  ? hi_sel     : '0;
    assign lo_in    = lo_wea  ? lo_sel     : '0;
    assign gpr_data = gpr_wea ? clz_result : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            unit_start  <= '0;
            hi_wea      <= 1'b0;
            lo_wea      <= 1'b0;
            gpr_wea     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unit_start  <= '0;
            hi_wea      <= 1'b0;
            lo_wea      <= 1'b0;
            gpr_wea     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    op_q    <= op_code;
                    wdata_q <= op_wdata;
                    unique case (1'b1)
                        op_code <= 3'd4: begin
                            state      <= ISSUE;
                            unit_start <= 5'(1) << op_code;
                        end
                        op_code == 3'd5, op_code == 3'd6: begin
                            state                     <= COMMIT;
                            done                      <= 1'b1;
                            {hi_wea, lo_wea, gpr_wea} <= wr_mask(op_code);
                        end
                        default: begin
                            done        <= 1'b1;
                            timeout_err <= 1'b1;
                        end
                    endcase
                end
                ISSUE: begin
                    state <= ARM;
                    cnt   <= '0;
                end
                ARM, RUN: begin
                    cnt <= cnt_inc;
                    if (cnt == TMO_LAST) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else if (state == ARM && sel_busy) begin
                        state <= RUN;
                    end else if ((state == RUN && !sel_busy) ||
                                 (state == ARM && cnt == ARM_LAST)) begin
                        // zero-latency units fall through ARM straight to commit
                        state                     <= COMMIT;
                        done                      <= 1'b1;
                        {hi_wea, lo_wea, gpr_wea} <= wr_mask(op_q);
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
